// File: rtl/aes_logic_pkg.sv
// Shared types and the lane function for the AES bitwise-logic unit.
// The function is one-bit so any operand width is handled by replicating it per lane.
package aes_logic_pkg;

  localparam int LOGIC_OP_W = 2;

  typedef enum logic [LOGIC_OP_W-1:0] {
    OP_NAND2B,
    OP_NAND,
    OP_AND,
    OP_XOR
  } logic_op_e;

  // a is the lane operand after the inversion mask has been applied
  function automatic logic logic_apply(input logic_op_e op, input logic a, input logic b);
    logic y;
    y = 1'b0;
    case (op)
      OP_NAND2B: y = ~(~a & b);
      OP_NAND:   y = ~(a & b);
      OP_AND:    y = a & b;
      OP_XOR:    y = a ^ b;
      default:   y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One pipeline slot: a valid bit plus a WIDTH-bit data register.
// Clear drops the valid bit only; data is kept so a flush costs no datapath toggling.
module logic_pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             unload_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] q_o
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  // NOTE: every next-state value gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = d_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: data is reset too, because out_y must read zero straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/nand2b_logic_pipe.sv
// Selectable bitwise two-operand logic unit with per-lane A inversion,
// followed by a STAGES-deep valid/ready pipeline whose bubbles collapse.
module nand2b_logic_pipe
  import aes_logic_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic [WIDTH-1:0]      in_inv,
  input  logic [LOGIC_OP_W-1:0] in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_y,
  output logic [CNT_W-1:0]      inflight,
  output logic                  busy
);

  logic [WIDTH-1:0]  a_lane;
  logic [WIDTH-1:0]  y_entry;
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_move;
  logic [STAGES-1:0] stage_load;
  logic [WIDTH-1:0]  stage_d [STAGES];
  logic [WIDTH-1:0]  stage_q [STAGES];
  logic              accept;
  logic              emit;
  logic [CNT_W-1:0]  inflight_d, inflight_q;

  assign a_lane = in_a ^ in_inv;

  always_comb begin
    y_entry = '0;
    for (int i = 0; i < WIDTH; i++) begin
      y_entry[i] = logic_apply(logic_op_e'(in_op), a_lane[i], in_b[i]);
    end
  end

  // Walk from the output backwards: a stage moves when the slot ahead is free or moving.
  always_comb begin
    logic down_free;
    logic mv;
    stage_move = '0;
    down_free  = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      mv            = stage_valid[k] && down_free;
      stage_move[k] = mv;
      down_free     = !stage_valid[k] || mv;
    end
  end

  assign in_ready = !rst && !flush && (!stage_valid[0] || stage_move[0]);
  assign accept   = in_valid && in_ready;
  assign emit     = stage_move[STAGES-1];

  always_comb begin
    stage_load    = '0;
    stage_load[0] = accept;
    for (int k = 1; k < STAGES; k++) begin
      stage_load[k] = stage_move[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_d[k] = y_entry;
    end else begin : g_body
      assign stage_d[k] = stage_q[k-1];
    end

    logic_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (flush),
      .load_i  (stage_load[k]),
      .unload_i(stage_move[k]),
      .d_i     (stage_d[k]),
      .valid_o (stage_valid[k]),
      .q_o     (stage_q[k])
    );
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !emit) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!accept && emit) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign out_valid = stage_valid[STAGES-1];
  assign out_y     = stage_q[STAGES-1];
  assign inflight  = inflight_q;
  assign busy      = (inflight_q != '0);

endmodule

// File: tb/tb_nand2b_logic_pipe.sv
// Randomised bench for nand2b_logic_pipe against a truth-table and queue-of-beats model.
module tb_nand2b_logic_pipe;

  localparam int W  = 32;
  localparam int S  = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]  in_a, in_b, in_inv, out_y;
  logic [1:0]    in_op;
  logic [CW-1:0] inflight;

  always #5 clk = ~clk;

  nand2b_logic_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_inv   (in_inv),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .inflight (inflight),
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: queue of accepted beats, each with its result and earliest cycle at the output.
  typedef struct {
    logic [W-1:0] y;
    int           rdy;
  } beat_t;
  beat_t mq[$];

  logic          obs_in_ready, obs_out_valid, obs_busy;
  logic [W-1:0]  obs_out_y;
  logic [CW-1:0] obs_inflight;
  logic          exp_in_ready, exp_out_valid, exp_busy;
  logic [W-1:0]  exp_y;
  logic [CW-1:0] exp_inflight;
  bit            last_acc;

  // Per-lane truth tables indexed by {a', b}.
  function automatic logic [W-1:0] ref_fn(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] inv);
    logic [3:0]   tt;
    logic [W-1:0] r;
    logic         ap;
    case (op)
      2'd0:    tt = 4'b1101;
      2'd1:    tt = 4'b0111;
      2'd2:    tt = 4'b1000;
      default: tt = 4'b0110;
    endcase
    for (int i = 0; i < W; i++) begin
      ap   = a[i] ^ inv[i];
      r[i] = tt[{ap, b[i]}];
    end
    return r;
  endfunction

  // One clock: drive at negedge, sample shortly after, then advance the model.
  task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] inv, input logic [1:0] op, input bit ordy,
                       input bit fl);
    beat_t nb;
    bit    hs;
    @(negedge clk);
    rst = 1'b0; in_valid = v; in_a = a; in_b = b; in_inv = inv; in_op = op;
    out_ready = ordy; flush = fl;
    #1;
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    obs_out_y     = out_y;
    obs_inflight  = inflight;
    obs_busy      = busy;
    exp_in_ready  = !fl && (mq.size() < S || ordy);
    exp_out_valid = (mq.size() > 0) && (cyc >= mq[0].rdy);
    exp_y         = (mq.size() > 0) ? mq[0].y : '0;
    exp_inflight  = CW'(mq.size());
    exp_busy      = (mq.size() != 0);
    last_acc      = v && exp_in_ready;
    hs            = exp_out_valid && ordy;
    if (fl) begin
      mq.delete();
    end else begin
      if (hs) begin
        nb = mq.pop_front();
        if (mq.size() > 0 && mq[0].rdy < cyc + 1) begin
          nb     = mq[0];
          nb.rdy = cyc + 1;
          mq[0]  = nb;
        end
      end
      if (last_acc) begin
        nb.y   = ref_fn(op, a, b, inv);
        nb.rdy = cyc + S;
        mq.push_back(nb);
      end
    end
    cyc++;
  endtask

  task automatic test_reset(input string name);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_inv = $urandom;
    in_op = 2'($urandom_range(0, 3)); out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL %s in_ready got=%b exp=0", name, in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s out_valid got=%b exp=0", name, out_valid); end
    total++; if (out_y !== '0) begin bad++; $display("FAIL %s out_y got=%h exp=0", name, out_y); end
    total++; if (inflight !== '0) begin bad++; $display("FAIL %s inflight got=%0d exp=0", name, inflight); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy got=%b exp=0", name, busy); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s in_ready_after got=%b exp=1", name, in_ready); end
    mq.delete();
    cyc += 3;
  endtask

  task automatic test_single();
    logic [W-1:0] a, b, want;
    a = 32'h0000FFFF; b = 32'h00FF00FF;
    want = ref_fn(2'd0, a, b, '0);
    drive(1'b1, a, b, '0, 2'd0, 1'b1, 1'b0);
    total++; if (obs_in_ready !== 1'b1) begin bad++; $display("FAIL single in_ready got=%b exp=1", obs_in_ready); end
    drive(1'b0, '0, '0, '0, 2'd0, 1'b1, 1'b0);
    total++; if (obs_out_valid !== 1'b0) begin bad++; $display("FAIL single early_valid got=%b exp=0", obs_out_valid); end
    total++; if (obs_inflight !== 3'd1) begin bad++; $display("FAIL single inflight1 got=%0d exp=1", obs_inflight); end
    total++; if (obs_busy !== 1'b1) begin bad++; $display("FAIL single busy got=%b exp=1", obs_busy); end
    drive(1'b0, '0, '0, '0, 2'd0, 1'b1, 1'b0);
    total++; if (obs_out_valid !== 1'b1) begin bad++; $display("FAIL single valid got=%b exp=1", obs_out_valid); end
    total++; if (obs_out_y !== want) begin bad++; $display("FAIL single out_y got=%h exp=%h", obs_out_y, want); end
    total++; if (obs_inflight !== 3'd1) begin bad++; $display("FAIL single inflight2 got=%0d exp=1", obs_inflight); end
    drive(1'b0, '0, '0, '0, 2'd0, 1'b1, 1'b0);
    total++; if (obs_out_valid !== 1'b0) begin bad++; $display("FAIL single late_valid got=%b exp=0", obs_out_valid); end
    total++; if (obs_inflight !== 3'd0) begin bad++; $display("FAIL single inflight3 got=%0d exp=0", obs_inflight); end
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL single busy_drop got=%b exp=0", obs_busy); end
  endtask

  task automatic test_ops();
    logic [W-1:0] a, b, inv, want;
    a = 32'hA5A5A5A5; b = 32'h0F0F0F0F; inv = 32'hFFFF0000;
    for (int op = 0; op < 4; op++) begin
      want = ref_fn(2'(op), a, b, inv);
      drive(1'b1, a, b, inv, 2'(op), 1'b1, 1'b0);
      drive(1'b0, '0, '0, '0, 2'd0, 1'b1, 1'b0);
      drive(1'b0, '0, '0, '0, 2'(3 - op), 1'b1, 1'b0);
      total++; if (obs_out_valid !== 1'b1) begin bad++; $display("FAIL op%0d valid got=%b exp=1", op, obs_out_valid); end
      total++; if (obs_out_y !== want) begin bad++; $display("FAIL op%0d out_y got=%h exp=%h", op, obs_out_y, want); end
    end
  endtask

  // mode 0: full rate, mode 1: out_ready low for cycles 3..7, mode 2: random valid/ready
  task automatic test_stream(input string name, input int n, input int mode);
    int           sent, got, cycles;
    bit           v, ordy, held, saw_block;
    logic [W-1:0] held_y;
    sent = 0; got = 0; cycles = 0; held = 0; saw_block = 0; held_y = '0;
    while ((sent < n || mq.size() > 0) && cycles < n * 4 + 40) begin
      v = (sent < n) && (mode != 2 || $urandom_range(0, 3) != 0);
      if (mode == 0) ordy = 1'b1;
      else if (mode == 1) ordy = !(cycles >= 3 && cycles <= 7);
      else ordy = ($urandom_range(0, 2) != 0);
      drive(v, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), ordy, 1'b0);
      if (last_acc) sent++;
      if (obs_out_valid === 1'b1 && ordy) got++;
      if (v && !exp_in_ready) saw_block = 1;
      total++; if (obs_in_ready !== exp_in_ready) begin bad++; $display("FAIL %s in_ready @%0d got=%b exp=%b", name, cycles, obs_in_ready, exp_in_ready); end
      total++; if (obs_out_valid !== exp_out_valid) begin bad++; $display("FAIL %s out_valid @%0d got=%b exp=%b", name, cycles, obs_out_valid, exp_out_valid); end
      total++; if (obs_inflight !== exp_inflight) begin bad++; $display("FAIL %s inflight @%0d got=%0d exp=%0d", name, cycles, obs_inflight, exp_inflight); end
      total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL %s busy @%0d got=%b exp=%b", name, cycles, obs_busy, exp_busy); end
      if (exp_out_valid) begin
        total++; if (obs_out_y !== exp_y) begin bad++; $display("FAIL %s out_y @%0d got=%h exp=%h", name, cycles, obs_out_y, exp_y); end
      end
      if (held) begin
        total++; if (obs_out_y !== held_y) begin bad++; $display("FAIL %s hold @%0d got=%h exp=%h", name, cycles, obs_out_y, held_y); end
      end
      held   = (obs_out_valid === 1'b1) && !ordy;
      held_y = obs_out_y;
      cycles++;
    end
    total++; if (got != n) begin bad++; $display("FAIL %s count got=%0d exp=%0d", name, got, n); end
    if (mode == 0) begin
      total++; if (cycles != n + S) begin bad++; $display("FAIL %s cycles got=%0d exp=%0d", name, cycles, n + S); end
    end
    if (mode == 1) begin
      total++; if (!saw_block) begin bad++; $display("FAIL %s backpressure got=none exp=in_ready low", name); end
    end
  endtask

  task automatic test_flush();
    drive(1'b1, $urandom, $urandom, $urandom, 2'd1, 1'b0, 1'b0);
    drive(1'b1, $urandom, $urandom, $urandom, 2'd3, 1'b0, 1'b0);
    drive(1'b1, 32'hDEADBEEF, 32'h12345678, '0, 2'd2, 1'b0, 1'b1);
    total++; if (obs_in_ready !== 1'b0) begin bad++; $display("FAIL flush in_ready got=%b exp=0", obs_in_ready); end
    total++; if (obs_inflight !== 3'd2) begin bad++; $display("FAIL flush pre_inflight got=%0d exp=2", obs_inflight); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, '0, 2'd0, 1'b1, 1'b0);
      total++; if (obs_out_valid !== 1'b0) begin bad++; $display("FAIL flush valid%0d got=%b exp=0", i, obs_out_valid); end
      total++; if (obs_inflight !== 3'd0) begin bad++; $display("FAIL flush inflight%0d got=%0d exp=0", i, obs_inflight); end
    end
  endtask

  task automatic test_reset_full();
    drive(1'b1, $urandom, $urandom, $urandom, 2'd0, 1'b0, 1'b0);
    drive(1'b1, $urandom, $urandom, $urandom, 2'd1, 1'b0, 1'b0);
    drive(1'b1, $urandom, $urandom, $urandom, 2'd2, 1'b0, 1'b0);
    total++; if (obs_in_ready !== 1'b0) begin bad++; $display("FAIL full in_ready got=%b exp=0", obs_in_ready); end
    total++; if (obs_inflight !== 3'd2) begin bad++; $display("FAIL full inflight got=%0d exp=2", obs_inflight); end
    test_reset("reset_full");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_inv = '0; in_op = 2'd0;
    test_reset("reset");
    test_single();
    test_ops();
    test_stream("backpressure", 6, 1);
    test_stream("back_to_back", 16, 0);
    test_flush();
    test_stream("random", 40, 2);
    test_reset_full();
    test_stream("after_reset", 8, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
